spi_rr_sched: RTL and testbench

Round-robin scheduler that shares one SPI read engine (16-bit, CS/SCK/MISO sensor reader) between up to four requesters, e.g. the TMP121 poller and an auxiliary sensor. Each grant sequences a single engine transaction: select device, start pulse, wait for done or timeout. After each transaction the scheduler returns the captured word and a status flag to the winning requester, then enforces a minimum CS-high gap. It sits between the requester logic (sample timers, UART formatter) and the SPI engine.

---
 rtl/spi_rr_sched.sv | 145 ++++++++++++++
 tb/tb_spi_rr_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_rr_sched.sv
// Round-robin scheduler sharing one SPI read engine between N_REQ requesters.
// Each grant runs one engine transaction (select, start, wait for done or
// timeout), returns the captured word plus an error flag to the winner, then
// holds the bus idle for GAP_CYC cycles so chip-select stays high long enough.
module spi_rr_sched #(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [1:0]        eng_sel,
    output logic              eng_start,
    output logic              eng_abort,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_data
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, GAP} state_t;

    state_t            state, state_nx;
    logic [1:0]        idx, idx_nx;
    logic [1:0]        rr_ptr, rr_ptr_nx;
    logic [TW-1:0]     tcnt, tcnt_nx;
    logic [GW-1:0]     gcnt, gcnt_nx;
    logic [N_REQ-1:0]  gnt_nx, rsp_valid_nx;
    logic [DATA_W-1:0] rsp_data_nx;
    logic              rsp_err_nx, eng_start_nx, eng_abort_nx;
    logic [1:0]        eng_sel_nx;
    logic              found;
    logic [1:0]        pick_idx;

    // First requester at or after the rr pointer, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        pick_idx = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % N_REQ]) begin
                found    = 1'b1;
                pick_idx = 2'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        rr_ptr_nx    = rr_ptr;
        tcnt_nx      = tcnt;
        gcnt_nx      = gcnt;
        gnt_nx       = gnt;
        rsp_valid_nx = '0;
        rsp_data_nx  = rsp_data;
        rsp_err_nx   = rsp_err;
        eng_sel_nx   = eng_sel;
        eng_start_nx = 1'b0;
        eng_abort_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx     = START;
                    idx_nx       = pick_idx;
                    gnt_nx       = N_REQ'(1) << pick_idx;
                    eng_sel_nx   = pick_idx;
                    eng_start_nx = 1'b1;
                end
            end
            START: begin
                // eng_done here is a stale pulse from nowhere; not ours yet.
                state_nx = WAIT;
                tcnt_nx  = '0;
            end
            WAIT: begin
                if (eng_done) begin
                    // Done wins over a simultaneous timeout.
                    state_nx     = RESP;
                    rsp_data_nx  = eng_data;
                    rsp_err_nx   = 1'b0;
                    rsp_valid_nx = gnt;
                end else if (tcnt == TW'(TIMEOUT_CYC)) begin
                    state_nx     = RESP;
                    rsp_data_nx  = '0;
                    rsp_err_nx   = 1'b1;
                    rsp_valid_nx = gnt;
                    eng_abort_nx = 1'b1;
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end
            RESP: begin
                state_nx  = GAP;
                gnt_nx    = '0;
                rr_ptr_nx = (idx == 2'(N_REQ - 1)) ? 2'd0 : idx + 2'd1;
                gcnt_nx   = GW'(GAP_CYC - 1);
            end
            GAP: begin
                if (gcnt == '0) state_nx = IDLE;
                else            gcnt_nx  = gcnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            idx       <= '0;
            rr_ptr    <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            eng_sel   <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            rr_ptr    <= rr_ptr_nx;
            tcnt      <= tcnt_nx;
            gcnt      <= gcnt_nx;
            gnt       <= gnt_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            rsp_err   <= rsp_err_nx;
            eng_sel   <= eng_sel_nx;
            eng_start <= eng_start_nx;
            eng_abort <= eng_abort_nx;
        end
    end

endmodule

// File: tb/tb_spi_rr_sched.sv
// Scoreboard bench for spi_rr_sched: stimulus pushes expected grants and
// responses into queues, a negedge monitor pops and compares them, and a
// small engine model answers eng_start after a scripted delay.
module tb_spi_rr_sched;

    localparam int N_REQ = 2, DATA_W = 16, GAP_CYC = 32, TIMEOUT_CYC = 1023;

    typedef struct { int idx; int gap; } grant_t;
    typedef struct { logic [1:0] vld; logic [15:0] data; logic err; int lat; } rsp_t;
    typedef struct { int dly; logic [15:0] data; } eng_t;

    logic clk = 1'b0, rstn = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] gnt, rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic rsp_err, eng_start, eng_abort;
    logic [1:0] eng_sel;
    logic eng_done = 1'b0;
    logic [DATA_W-1:0] eng_data = '0;

    grant_t gq[$];
    rsp_t   rq[$];
    eng_t   eq[$];

    int n_vec = 0, n_miss = 0;
    int cyc = 0, start_cyc = 0, last_rsp_cyc = 0, abort_cnt = 0;
    bit prev_start = 0, chk_low = 0;

    always #5 clk = ~clk;

    spi_rr_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC),
                   .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_sel(eng_sel),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_done(eng_done),
        .eng_data(eng_data));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares grants and responses against the scoreboard queues.
    initial begin
        grant_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_low) begin
                chk("gnt_clear_after_rsp", 32'(gnt), 0);
                chk("rsp_valid_one_cycle", 32'(rsp_valid), 0);
                chk_low = 0;
            end
            if (eng_abort) abort_cnt++;
            if (prev_start) chk("start_one_cycle", 32'(eng_start), 0);
            prev_start = eng_start;
            if (eng_start) begin
                chk("grant_expected", 32'(gq.size() > 0), 1);
                if (gq.size() > 0) begin
                    g = gq.pop_front();
                    chk("grant_onehot", 32'(gnt), 32'(1) << g.idx);
                    chk("eng_sel", 32'(eng_sel), 32'(g.idx));
                    if (g.gap > 0) chk("gap_rsp_to_start", 32'(cyc - last_rsp_cyc), 32'(g.gap));
                end
                start_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                chk("rsp_expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(r.vld));
                    chk("rsp_data", 32'(rsp_data), 32'(r.data));
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("eng_abort", 32'(eng_abort), 32'(r.err));
                    chk("gnt_in_resp", 32'(gnt), 32'(r.vld));
                    if (r.lat > 0) chk("start_to_rsp", 32'(cyc - start_cyc), 32'(r.lat));
                end
                last_rsp_cyc = cyc;
                chk_low = 1;
            end
        end
    end

    // Engine model: answer each start after a scripted delay (dly<0: never).
    initial begin
        eng_t e;
        forever begin
            @(negedge clk);
            if (eng_start && rstn && eq.size() > 0) begin
                e = eq.pop_front();
                if (e.dly >= 0) begin
                    repeat (e.dly) @(negedge clk);
                    eng_done = 1'b1;
                    eng_data = e.data;
                    @(negedge clk);
                    eng_done = 1'b0;
                    eng_data = 16'hDEAD;
                end
            end
        end
    end

    // Watchdog so the run cannot hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(int budget);
        int i;
        for (i = 0; i < budget && rq.size() > 0; i++) @(negedge clk);
        chk("rsp_within_budget", 32'(rq.size()), 0);
    endtask

    task automatic settle();
        req = '0;
        repeat (GAP_CYC + 6) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_eng_start", 32'({rsp_err, eng_sel, eng_start, eng_abort}), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, engine answers 544 cycles after start: done at k+545
        eq.push_back('{544, 16'hC8F8});
        gq.push_back('{0, 0});
        rq.push_back('{2'b01, 16'hC8F8, 1'b0, 545});
        req = 2'b01;
        wait_rsp(2000);
        settle();

        // Withdrawal: requester 1 drops mid-WAIT, response still arrives
        eq.push_back('{100, 16'h0B0B});
        gq.push_back('{1, 0});
        rq.push_back('{2'b10, 16'h0B0B, 1'b0, 101});
        req = 2'b10;
        repeat (20) @(negedge clk);
        req = 2'b00;
        wait_rsp(500);
        repeat (GAP_CYC + 10) @(negedge clk);

        // Contention: pointer is 0, expect 0,1,0,1 spaced GAP_CYC+2 edges
        for (int i = 0; i < 4; i++) begin
            eq.push_back('{10, 16'hA000 + 16'(i)});
            gq.push_back('{i % 2, (i == 0) ? 0 : GAP_CYC + 2});
            rq.push_back('{(i % 2 == 0) ? 2'b01 : 2'b10, 16'hA000 + 16'(i), 1'b0, 11});
        end
        req = 2'b11;
        wait_rsp(1000);
        settle();

        // Timeout: no done, abort after TIMEOUT_CYC+1 WAIT cycles
        eq.push_back('{-1, 16'h0000});
        gq.push_back('{0, 0});
        rq.push_back('{2'b01, 16'h0000, 1'b1, TIMEOUT_CYC + 2});
        req = 2'b01;
        wait_rsp(3000);
        settle();

        // Next request served normally
        eq.push_back('{20, 16'h5A5A});
        gq.push_back('{0, 0});
        rq.push_back('{2'b01, 16'h5A5A, 1'b0, 21});
        req = 2'b01;
        wait_rsp(500);
        settle();

        // Done on the timeout edge: done wins, no abort
        eq.push_back('{TIMEOUT_CYC + 1, 16'h1234});
        gq.push_back('{0, 0});
        rq.push_back('{2'b01, 16'h1234, 1'b0, TIMEOUT_CYC + 2});
        req = 2'b01;
        wait_rsp(3000);
        settle();

        // Async reset mid-WAIT, between clock edges
        eq.push_back('{-1, 16'h0000});
        gq.push_back('{0, 0});
        req = 2'b01;
        repeat (50) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 0);
        chk("async_rst_rsp_data", 32'(rsp_data), 0);
        chk("async_rst_misc", 32'({rsp_valid, rsp_err, eng_sel, eng_start, eng_abort}), 0);
        req = 2'b00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        eq.push_back('{30, 16'hBEEF});
        gq.push_back('{1, 0});
        rq.push_back('{2'b10, 16'hBEEF, 1'b0, 31});
        req = 2'b10;
        @(negedge clk);
        chk("post_rst_start", 32'({eng_start, gnt}), 32'({1'b1, 2'b10}));
        wait_rsp(500);
        settle();

        chk("grant_queue_drained", 32'(gq.size()), 0);
        chk("abort_pulses", 32'(abort_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
